// File: rtl/grant_sequencer.sv
// grant_sequencer: locks the shared transfer channel to the arbiter's winner,
// runs one fixed-length valid/ready burst for it, then releases ownership and
// idles for one GAP cycle so the arbiter re-evaluates before the next capture.
module grant_sequencer #(
   parameter int N       = 4,
   parameter int BEATS   = 4,
   parameter int TIMEOUT = 16,
   parameter int IDW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   request,
   input  logic [N-1:0]   arb_grant,
   input  logic           src_valid,
   input  logic           dst_ready,
   output logic [N-1:0]   owner,
   output logic [IDW-1:0] owner_id,
   output logic           busy,
   output logic           dst_valid,
   output logic           src_ready,
   output logic           last,
   output logic           done,
   output logic           abort,
   output logic           grant_err
);

   localparam int BW = $clog2(BEATS + 1);
   localparam int SW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t         state, state_nxt;
   logic [N-1:0]   owner_nxt;
   logic [IDW-1:0] owner_id_nxt;
   logic [BW-1:0]  beat_cnt, beat_cnt_nxt;
   logic [SW-1:0]  stall_cnt, stall_cnt_nxt;
   logic           done_nxt, abort_nxt, grant_err_nxt;

   logic           accept;
   logic           final_beat;
   logic           stall_limit;
   logic           owner_lost;
   logic           grant_onehot;
   logic           grant_ok;
   logic [IDW-1:0] grant_idx;

   // Qualify the arbiter grant: exactly one bit set, and that bit is requesting.
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (arb_grant[i]) grant_idx = IDW'(i);
      end
   end

   assign grant_onehot = (arb_grant != '0) && ((arb_grant & (arb_grant - 1'b1)) == '0);
   assign grant_ok     = grant_onehot && ((arb_grant & request) != '0);

   assign busy        = (state == BUSY);
   assign accept      = busy && src_valid && dst_ready;
   assign final_beat  = (beat_cnt == BW'(BEATS - 1));
   assign stall_limit = (stall_cnt == SW'(TIMEOUT - 1));
   assign owner_lost  = !request[owner_id];

   assign dst_valid = busy && src_valid;
   assign src_ready = busy && dst_ready;
   assign last      = busy && final_beat;

   // Next-state and next-register logic for the IDLE/BUSY/GAP sequence.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt     = state;
      owner_nxt     = owner;
      owner_id_nxt  = owner_id;
      beat_cnt_nxt  = beat_cnt;
      stall_cnt_nxt = stall_cnt;
      done_nxt      = 1'b0;
      abort_nxt     = 1'b0;
      grant_err_nxt = grant_err;

      unique case (state)
         IDLE: begin
            if (request != '0) begin
               if (grant_ok) begin
                  state_nxt     = BUSY;
                  owner_nxt     = arb_grant;
                  owner_id_nxt  = grant_idx;
                  beat_cnt_nxt  = '0;
                  stall_cnt_nxt = '0;
               end else begin
                  grant_err_nxt = 1'b1;
               end
            end
         end

         BUSY: begin
            // A final-beat accept always wins over timeout and request drop.
            if (accept && final_beat) begin
               state_nxt     = GAP;
               done_nxt      = 1'b1;
               owner_nxt     = '0;
               owner_id_nxt  = '0;
               beat_cnt_nxt  = '0;
               stall_cnt_nxt = '0;
            end else if (owner_lost || (!accept && stall_limit)) begin
               state_nxt     = GAP;
               abort_nxt     = 1'b1;
               owner_nxt     = '0;
               owner_id_nxt  = '0;
               beat_cnt_nxt  = '0;
               stall_cnt_nxt = '0;
            end else if (accept) begin
               beat_cnt_nxt  = beat_cnt + BW'(1);
               stall_cnt_nxt = '0;
            end else begin
               stall_cnt_nxt = stall_cnt + SW'(1);
            end
         end

         GAP: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt     = IDLE;
            owner_nxt     = '0;
            owner_id_nxt  = '0;
            beat_cnt_nxt  = '0;
            stall_cnt_nxt = '0;
         end
      endcase
   end

   // State and register update; reset drops ownership immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         owner_id  <= '0;
         beat_cnt  <= '0;
         stall_cnt <= '0;
         done      <= 1'b0;
         abort     <= 1'b0;
         grant_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state     <= state_nxt;
         owner     <= owner_nxt;
         owner_id  <= owner_id_nxt;
         beat_cnt  <= beat_cnt_nxt;
         stall_cnt <= stall_cnt_nxt;
         done      <= done_nxt;
         abort     <= abort_nxt;
         grant_err <= grant_err_nxt;
      end
   end

endmodule

// File: doc/grant_sequencer.md
Name: grant_sequencer

Overview:
- Sits directly downstream of the fixed-priority arbiter.
- Samples the arbiter's one-hot grant when idle, locks ownership of the shared transfer channel to the winner, and runs a fixed-length burst with valid/ready handshake.
- Releases ownership on burst completion, owner request drop, or stall timeout.
- Forces a one-cycle gap between owners so the arbiter re-evaluates.

Parameters:
- N, 4, number of requesters; must equal the arbiter's request width.
- BEATS, 4, beats per burst (>=1).
- TIMEOUT, 16, consecutive BUSY cycles without an accepted beat before abort (>=2).
- IDW, $clog2(N) (min 1), derived width of owner_id.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- request  in  N  raw requests; also fed to the arbiter.
- arb_grant  in  N  one-hot grant from the fixed-priority arbiter (combinational on request).
- src_valid  in  1  beat valid from the owner (externally muxed by owner_id).
- dst_ready  in  1  downstream ready.
- owner  out  N  registered one-hot grant held to requesters.
- owner_id  out  IDW  binary index of owner.
- busy  out  1  burst in progress.
- dst_valid  out  1  busy & src_valid.
- src_ready  out  1  busy & dst_ready.
- last  out  1  busy & (beat_cnt == BEATS-1).
- done  out  1  one-cycle pulse on final-beat accept.
- abort  out  1  one-cycle pulse on early release.
- grant_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async, immediate): state=IDLE, owner=0, owner_id=0, busy=0, done=0, abort=0, grant_err=0, beat_cnt=0, stall_cnt=0.
- Reset mid-burst drops ownership in the same instant; no done or abort pulse is generated.
- Accept condition: beat accepted = busy & src_valid & dst_ready.
- States:
  - IDLE: busy=0.
    - If |request and arb_grant is exactly one-hot and arb_grant & request != 0: owner<=arb_grant, owner_id<=encode(arb_grant), beat_cnt<=0, stall_cnt<=0, next BUSY. busy rises one cycle after the grant is sampled.
    - If |request and arb_grant is zero, multi-hot, or points at a non-requesting bit: grant_err<=1 (sticky until rst), no capture, stay IDLE.
    - If request==0: stay IDLE; arb_grant is ignored.
  - BUSY: owner held constant regardless of arb_grant changes.
    - On accept: beat_cnt++, stall_cnt<=0.
    - On accept with beat_cnt==BEATS-1: done=1 next cycle, next GAP.
    - No accept: stall_cnt++. When stall_cnt reaches TIMEOUT-1 without an accept: abort=1, next GAP.
    - request[owner_id]==0 with no final-beat accept in the same cycle: abort=1, next GAP.
    - Final-beat accept and request drop in the same cycle: done only, no abort.
    - Final-beat accept on the timeout cycle: done only, no abort.
  - GAP: exactly one cycle. owner=0, busy=0, beat_cnt=0, stall_cnt=0, then IDLE. No capture in GAP.
- Counter widths: beat_cnt is $clog2(BEATS+1) bits; stall_cnt is $clog2(TIMEOUT+1) bits. Neither counter wraps: BUSY always exits before overflow.
- done and abort are registered, are mutually exclusive, and assert in the first GAP cycle.
- Throughput: one accepted beat per cycle. Minimum owner-to-owner turnaround = BEATS + 2 cycles (capture, BEATS beats, GAP).
- owner changes only on IDLE->BUSY and BUSY->GAP transitions.

Test Plan:
- Single burst: request=4'b0100, arb_grant=4'b0100, src_valid=dst_ready=1 -> owner=4'b0100 and owner_id=2 one cycle later; last high on beat 4; done pulse; owner=0 for exactly 1 GAP cycle.
- Priority handover: request=4'b0011 with the arbiter granting bit 0 -> bit 0 completes 4 beats; after GAP, re-capture with request=4'b0010 gives owner=4'b0010.
- Backpressure: dst_ready toggling 1,0,1,0 -> beat_cnt advances only on ready cycles, dst_valid stays high, done after the 4th accept, no abort.
- Timeout: owner granted, src_valid=0 for 16 cycles -> abort pulse at the end of cycle 16, no done, GAP, then IDLE.
- Request drop: owner requester deasserts after beat 2 -> abort next cycle. Repeat with the drop coinciding with the beat-4 accept -> done only.
- Error and reset: request=4'b1000 with arb_grant=4'b0011 -> grant_err=1 and stays set, no capture. Then assert rst mid-burst -> all outputs 0 immediately and grant_err cleared.
